data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of REQ-state cycles spent waiting for bus_ack before a bus error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MemWriteM  input  1  store in Memory stage.
REQ-005 ResultSrcM  input  2  2'b01 marks a load in Memory stage.
REQ-006 funct3M  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 ALUResultM  input  32  byte address.
REQ-008 WriteDataM  input  32  store data, right-aligned.
REQ-009 bus_req  output  1  request valid.
REQ-010 bus_we  output  1  1 for store.
REQ-011 bus_addr  output  32  word address, {ALUResultM[31:2],2'b00}.
REQ-012 bus_be  output  4  byte enables.
REQ-013 bus_wdata  output  32  lane-aligned store data.
REQ-014 bus_ack  input  1  responder completion, sampled only in REQ.
REQ-015 bus_rdata  input  32  read word, valid with bus_ack.
REQ-016 ReadDataM  output  32  extended load result.
REQ-017 StallM  output  1  hold Fetch through Memory stages.
REQ-018 MisalignM  output  1  misaligned access flag.
REQ-019 BusErrM  output  1  timeout flag.

Function
REQ-020 An access SHALL be MemWriteM=1 or ResultSrcM=2'b01; both at once SHALL be treated as a store.
REQ-021 Alignment: h/hu need addr[0]=0, w needs addr[1:0]=00; otherwise MisalignM=1 in the same cycle (combinational), no bus request, StallM=0.
REQ-022 FSM states IDLE, REQ, DONE; IDLE->REQ on aligned access; REQ->DONE on bus_ack or timeout; DONE->IDLE unconditionally.
REQ-023 On IDLE->REQ, address, be, wdata, we, and funct3 SHALL be registered; bus outputs SHALL be driven only from these registers.
REQ-024 bus_req=1 exactly while in REQ; all bus outputs stable throughout REQ.
REQ-025 StallM = (IDLE & aligned access) | REQ; StallM=0 in DONE, so the instruction retires from Memory in DONE and DONE never retriggers.
REQ-026 Minimum latency: access enters IDLE, ack in first REQ cycle, DONE next; the instruction SHALL occupy Memory for 3 cycles.
REQ-027 Store lanes: sb be=4'b0001<<addr[1:0], data byte replicated x4; sh be=0011 (addr[1]=0) or 1100, halfword replicated x2; sw be=1111.
REQ-028 Load: selected byte/halfword sign-extended (b,h) or zero-extended (bu,hu); w passes through; for stores be SHALL be 0000 on loads.
REQ-029 Load data SHALL be captured on bus_ack into a register; ReadDataM SHALL show it in DONE and hold until the next capture.
REQ-030 A wait counter SHALL clear on entering REQ and increment each REQ cycle without ack; reaching TIMEOUT_CYCLES SHALL force DONE with BusErrM=1 for that DONE cycle only and captured data 32'h0.
REQ-031 bus_ack and timeout in the same cycle: ack SHALL win, BusErrM=0.
REQ-032 bus_ack outside REQ SHALL be ignored.

Reset
REQ-033 On reset: state IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, ReadDataM=0, counter=0, BusErrM=0.
REQ-034 Reset in REQ SHALL abort: bus_req=0 from the following cycle, no DONE, no data capture.

Structure
REQ-035 Shared package riscv_mem_pkg SHALL hold funct3 size encodings, the ResultSrc load code 2'b01, and the state enum.
REQ-036 Load extension logic SHALL be a separate combinational sub-module load_extend (inputs rdata, addr[1:0], funct3; output 32-bit result).

Verification
REQ-037 lw at 0x100, ack in first REQ cycle with rdata 0xDEADBEEF -> bus_addr 0x100, be 0000, StallM high 2 cycles, ReadDataM 0xDEADBEEF in DONE.
REQ-038 sb addr 0x103 data 0x000000A5 -> bus_be 1000, bus_wdata 0xA5A5A5A5, bus_we 1.
REQ-039 lb addr 0x102, rdata 0x00800000 -> ReadDataM 0xFFFFFF80; lbu same -> 0x00000080.
REQ-040 lh addr 0x101 -> MisalignM 1 same cycle, bus_req never asserts, StallM 0.
REQ-041 TIMEOUT_CYCLES=4, no ack -> DONE after 4 REQ cycles, BusErrM 1 one cycle, ReadDataM 0; ack on 4th cycle -> BusErrM 0.
REQ-042 Reset asserted in 2nd REQ cycle -> bus_req 0 next cycle, state IDLE, StallM 0 with no access present.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the Memory-stage data bus controller: access size codes,
// the load result-source code and the controller state encoding.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_e;

  // size is funct3[1:0]: signedness does not affect alignment
  function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~a[0];
      default: return (a == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Word-addressed data bus between the Memory-stage controller and its responder.
interface data_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/data_mem_ctrl_load_extend.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage data bus controller: one registered bus transaction per aligned
// load/store, stalling the pipeline until the responder acks or the wait times out.
module data_mem_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            funct3M,
  input  logic [31:0]           ALUResultM,
  input  logic [31:0]           WriteDataM,
  data_mem_ctrl_if.master       bus,
  output logic [31:0]           ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  BusErrM
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state;
  logic          access;
  logic          aligned;
  logic          timeout;
  logic [3:0]    be_next;
  logic [31:0]   wdata_next;
  logic [31:0]   load_ext;

  logic          req_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [1:0]    addr_lo_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [2:0]    funct3_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [CW-1:0] wait_cnt;

  assign access    = MemWriteM | (ResultSrcM == RESULT_SRC_LOAD);
  assign aligned   = addr_aligned(funct3M[1:0], ALUResultM[1:0]);
  assign MisalignM = access & ~aligned;
  assign StallM    = ((state == IDLE) & access & aligned) | (state == REQ);
  assign timeout   = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Loads leave be at zero; stores replicate the datum across every lane.
  always_comb begin
    be_next    = '0;
    wdata_next = '0;
    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          be_next    = 4'b0001 << ALUResultM[1:0];
          wdata_next = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          be_next    = ALUResultM[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{WriteDataM[15:0]}};
        end
        default: begin
          be_next    = '1;
          wdata_next = WriteDataM;
        end
      endcase
    end
  end

  load_extend u_load_extend (
    .rdata  (bus.rdata),
    .addr   (addr_lo_q),
    .funct3 (funct3_q),
    .result (load_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      addr_lo_q <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (access && aligned) begin
            state     <= REQ;
            req_q     <= 1'b1;
            we_q      <= MemWriteM;
            addr_q    <= {ALUResultM[31:2], 2'b00};
            addr_lo_q <= ALUResultM[1:0];
            be_q      <= be_next;
            wdata_q   <= wdata_next;
            funct3_q  <= funct3M;
            wait_cnt  <= '0;
          end
        end
        REQ: begin
          // ack takes priority over an expiring wait
          if (bus.ack) begin
            state <= DONE;
            req_q <= 1'b0;
            if (!we_q) rdata_q <= load_ext;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timeout) begin
              state   <= DONE;
              req_q   <= 1'b0;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.be    = be_q;
  assign bus.wdata = wdata_q;
  assign ReadDataM = rdata_q;
  assign BusErrM   = err_q;

endmodule
